// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard unit and its multiplier scoreboard.
package hazard_pkg;

  localparam int RA_W_DEF    = 4;
  localparam int NREG_DEF    = 16;
  localparam int NRD_DEF     = 3;
  localparam int MUL_LAT_DEF = 3;
  localparam int PC_REG      = NREG_DEF - 1;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_M   = 2'b10,
    FWD_MUL = 2'b11
  } fwd_sel_e;

endpackage

// File: rtl/mul_scoreboard.sv
// Tracks the single in-flight multi-cycle multiply: latency counter, destination, pending bits,
// and the decode-stage RAW/WAW and structural stall terms derived from them.
module mul_scoreboard
  import hazard_pkg::*;
#(
  parameter int RA_W    = RA_W_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int NRD     = NRD_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                MulIssueE,
  input  logic [RA_W-1:0]     wa3E,
  input  logic [NRD*RA_W-1:0] raD,
  input  logic [RA_W-1:0]     wa3D,
  input  logic                RegWriteD,
  input  logic                MulD,
  output logic                MulBusy,
  output logic                MulDone,
  output logic [RA_W-1:0]     MulDst,
  output logic                sbStallD,
  output logic                mulStallD
);

  localparam logic [RA_W-1:0] PC_IDX = RA_W'(NREG - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RA_W-1:0]  dst_q, dst_d;
  logic [NREG-1:0]  pend_q, pend_d;
  logic             issue_ok;

  assign MulBusy  = (cnt_q != '0);
  assign MulDone  = (cnt_q == CNT_W'(1));
  assign MulDst   = dst_q;
  // A new issue is allowed in the cycle the previous result retires.
  assign issue_ok = MulIssueE && (cnt_q <= CNT_W'(1));

  always_comb begin
    cnt_d  = cnt_q;
    dst_d  = dst_q;
    pend_d = pend_q;
    if (issue_ok) begin
      cnt_d = CNT_W'(MUL_LAT);
      dst_d = wa3E;
    end else if (MulBusy) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (MulDone) pend_d[dst_q] = 1'b0;
    // Set after clear so a re-issue to the same destination stays pending.
    if (issue_ok && (wa3E != PC_IDX)) pend_d[wa3E] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dst_q  <= '0;
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      dst_q  <= dst_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    sbStallD = RegWriteD && pend_q[wa3D];
    for (int i = 0; i < NRD; i++) begin
      if (pend_q[raD[i*RA_W +: RA_W]] && !(MulDone && (raD[i*RA_W +: RA_W] == dst_q)))
        sbStallD = 1'b1;
    end
  end

  assign mulStallD = MulD && MulBusy && (cnt_q > CNT_W'(1));

endmodule

// File: rtl/hazard_unit_sb.sv
// Hazard unit for the 5-stage pipeline: E-stage operand forwarding selects plus the
// decode/fetch stall and flush combine, with a scoreboarded multi-cycle multiplier.
module hazard_unit_sb
  import hazard_pkg::*;
#(
  parameter int RA_W    = RA_W_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int NRD     = NRD_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                RegWriteM,
  input  logic                RegWriteWB,
  input  logic [NRD*RA_W-1:0] raE,
  input  logic [RA_W-1:0]     wa3M,
  input  logic [RA_W-1:0]     wa3WB,
  output logic [NRD*2-1:0]    fwdE,
  input  logic [NRD*RA_W-1:0] raD,
  input  logic [RA_W-1:0]     wa3D,
  input  logic                RegWriteD,
  input  logic                MulD,
  input  logic                MemtoRegE,
  input  logic [RA_W-1:0]     wa3E,
  input  logic                MulIssueE,
  input  logic                PCSrcD,
  input  logic                PCSrcE,
  input  logic                PCSrcM,
  input  logic                PCSrcWB,
  input  logic                BranchTakenE,
  output logic                StallF,
  output logic                StallD,
  output logic                FlushD,
  output logic                FlushE,
  output logic                MulBusy,
  output logic                MulDone,
  output logic [RA_W-1:0]     MulDst
);

  localparam logic [RA_W-1:0] PC_IDX = RA_W'(NREG - 1);

  logic sbStallD, mulStallD, ldrStallD, hzD, PCWrPendingF;

  mul_scoreboard #(
    .RA_W   (RA_W),
    .NREG   (NREG),
    .NRD    (NRD),
    .MUL_LAT(MUL_LAT)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .MulIssueE(MulIssueE),
    .wa3E     (wa3E),
    .raD      (raD),
    .wa3D     (wa3D),
    .RegWriteD(RegWriteD),
    .MulD     (MulD),
    .MulBusy  (MulBusy),
    .MulDone  (MulDone),
    .MulDst   (MulDst),
    .sbStallD (sbStallD),
    .mulStallD(mulStallD)
  );

  always_comb begin
    fwdE = '0;
    if (rst_n) begin
      for (int i = 0; i < NRD; i++) begin
        if (raE[i*RA_W +: RA_W] != PC_IDX) begin
          if (RegWriteM && (raE[i*RA_W +: RA_W] == wa3M))
            fwdE[2*i +: 2] = FWD_M;
          else if (RegWriteWB && (raE[i*RA_W +: RA_W] == wa3WB))
            fwdE[2*i +: 2] = FWD_WB;
          else if (MulDone && (raE[i*RA_W +: RA_W] == MulDst))
            fwdE[2*i +: 2] = FWD_MUL;
        end
      end
    end
  end

  always_comb begin
    ldrStallD = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      if (MemtoRegE && (raD[i*RA_W +: RA_W] == wa3E)) ldrStallD = 1'b1;
    end
  end

  assign hzD          = ldrStallD | sbStallD | mulStallD;
  assign PCWrPendingF = PCSrcD | PCSrcE | PCSrcM;

  // Reset holds D/E cleared and releases all stalls.
  assign StallF = rst_n & (hzD | PCWrPendingF);
  assign StallD = rst_n & hzD;
  assign FlushE = !rst_n | hzD | BranchTakenE;
  assign FlushD = !rst_n | PCWrPendingF | PCSrcWB | BranchTakenE;

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed bench for hazard_unit_sb: expected outputs queued per step, compared at the falling edge.
module tb_hazard_unit_sb;

  localparam int RA_W = 4;
  localparam int NRD  = 3;
  localparam logic [3:0] PC = 4'(hazard_pkg::PC_REG);

  typedef struct packed {
    logic [5:0] fwd;
    logic [3:0] sdf;   // {StallF, StallD, FlushD, FlushE}
    logic       busy;
    logic       done;
    logic [3:0] dst;
  } obs_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                RegWriteM, RegWriteWB, RegWriteD, MulD, MemtoRegE, MulIssueE;
  logic                PCSrcD, PCSrcE, PCSrcM, PCSrcWB, BranchTakenE;
  logic [NRD*RA_W-1:0] raE, raD;
  logic [RA_W-1:0]     wa3M, wa3WB, wa3D, wa3E;
  logic [NRD*2-1:0]    fwdE;
  logic                StallF, StallD, FlushD, FlushE, MulBusy, MulDone;
  logic [RA_W-1:0]     MulDst;

  int checks   = 0;
  int failures = 0;
  obs_t  exp_q[$];
  string tag_q[$];

  hazard_unit_sb dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteM(RegWriteM), .RegWriteWB(RegWriteWB), .raE(raE), .wa3M(wa3M), .wa3WB(wa3WB),
    .fwdE(fwdE), .raD(raD), .wa3D(wa3D), .RegWriteD(RegWriteD), .MulD(MulD),
    .MemtoRegE(MemtoRegE), .wa3E(wa3E), .MulIssueE(MulIssueE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcWB(PCSrcWB),
    .BranchTakenE(BranchTakenE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .MulBusy(MulBusy), .MulDone(MulDone), .MulDst(MulDst)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ra3(input int p2, input int p1, input int p0);
    return {4'(p2), 4'(p1), 4'(p0)};
  endfunction

  task automatic idle();
    RegWriteM = 0; RegWriteWB = 0; RegWriteD = 0; MulD = 0; MemtoRegE = 0; MulIssueE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcWB = 0; BranchTakenE = 0;
    raE = '0; raD = '0; wa3M = '0; wa3WB = '0; wa3D = '0; wa3E = '0;
  endtask

  task automatic push(input string tag, input logic [5:0] f, input logic [3:0] sdf,
                      input logic b, input logic d, input logic [3:0] dst);
    obs_t e;
    e = '{fwd: f, sdf: sdf, busy: b, done: d, dst: dst};
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // One pipeline cycle: compare at the falling edge, return 1 time unit after the next rising edge.
  task automatic cyc();
    obs_t  o, e;
    string t;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_underflow observed=empty expected=entry");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = '{fwd: fwdE, sdf: {StallF, StallD, FlushD, FlushE}, busy: MulBusy, done: MulDone, dst: MulDst};
      checks++;
      assert (o === e) else begin
        failures++;
        $error("FAIL %s observed fwd=%b sdf=%b busy=%b done=%b dst=%0d expected fwd=%b sdf=%b busy=%b done=%b dst=%0d",
               t, o.fwd, o.sdf, o.busy, o.done, o.dst, e.fwd, e.sdf, e.busy, e.done, e.dst);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // A multiply may only issue while the unit is idle or retiring.
  always @(negedge clk) begin
    if (rst_n && MulIssueE) begin
      checks++;
      assert (!(MulBusy && !MulDone)) else begin
        failures++;
        $error("FAIL illegal_issue observed busy=%b done=%b expected not busy or done", MulBusy, MulDone);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    RegWriteM = 1; wa3M = 3; raE = ra3(0, 0, 3); MemtoRegE = 1; wa3E = 5; raD = ra3(0, 5, 0);
    push("reset", 6'b000000, 4'b0011, 0, 0, 0); cyc();

    // Forwarding priority and PC exclusion
    rst_n = 1'b1;
    idle(); RegWriteM = 1; wa3M = 3; RegWriteWB = 1; wa3WB = 3; raE = ra3(0, 0, 3);
    push("fwd_m_over_wb", 6'b000010, 4'b0000, 0, 0, 0); cyc();
    RegWriteM = 0;
    push("fwd_wb", 6'b000001, 4'b0000, 0, 0, 0); cyc();
    RegWriteM = 1; wa3M = PC; raE = ra3(PC, 0, 3);
    push("fwd_pc_excluded", 6'b000001, 4'b0000, 0, 0, 0); cyc();
    RegWriteM = 1; wa3M = 4; RegWriteWB = 1; wa3WB = 6; raE = ra3(6, 4, 1);
    push("fwd_per_port", 6'b011000, 4'b0000, 0, 0, 0); cyc();

    // Load-use
    idle(); MemtoRegE = 1; wa3E = 5; raD = ra3(0, 5, 0);
    push("load_use", 6'b000000, 4'b1101, 0, 0, 0); cyc();
    MemtoRegE = 0;
    push("load_use_clear", 6'b000000, 4'b0000, 0, 0, 0); cyc();

    // Multiply to r7 with a dependent reader in D
    idle(); MulIssueE = 1; wa3E = 7;
    push("mul_issue", 6'b000000, 4'b0000, 0, 0, 0); cyc();
    idle(); raD = ra3(0, 0, 7);
    push("raw_stall1", 6'b000000, 4'b1101, 1, 0, 7); cyc();
    push("raw_stall2", 6'b000000, 4'b1101, 1, 0, 7); cyc();
    raE = ra3(0, 0, 7);
    push("mul_done_fwd", 6'b000011, 4'b0000, 1, 1, 7); cyc();
    raE = '0;
    push("mul_idle", 6'b000000, 4'b0000, 0, 0, 7); cyc();

    // Structural stall on a second multiply, then issue while the previous one retires
    idle(); MulIssueE = 1; wa3E = 8;
    push("mul2_issue", 6'b000000, 4'b0000, 0, 0, 7); cyc();
    idle(); MulD = 1; RegWriteD = 1; wa3D = 9;
    push("struct_stall1", 6'b000000, 4'b1101, 1, 0, 8); cyc();
    push("struct_stall2", 6'b000000, 4'b1101, 1, 0, 8); cyc();
    push("struct_release", 6'b000000, 4'b0000, 1, 1, 8); cyc();
    idle(); MulIssueE = 1; wa3E = 9;
    push("mul3_issue", 6'b000000, 4'b0000, 0, 0, 8); cyc();
    idle();
    push("mul3_busy1", 6'b000000, 4'b0000, 1, 0, 9); cyc();
    push("mul3_busy2", 6'b000000, 4'b0000, 1, 0, 9); cyc();
    MulIssueE = 1; wa3E = 9;
    push("issue_at_done", 6'b000000, 4'b0000, 1, 1, 9); cyc();
    idle(); raD = ra3(9, 0, 0);
    push("set_wins1", 6'b000000, 4'b1101, 1, 0, 9); cyc();
    push("set_wins2", 6'b000000, 4'b1101, 1, 0, 9); cyc();
    push("done_bypass", 6'b000000, 4'b0000, 1, 1, 9); cyc();

    // PC writes walking down the pipe, branches
    idle(); PCSrcD = 1;
    push("pc_d", 6'b000000, 4'b1010, 0, 0, 9); cyc();
    idle(); PCSrcE = 1;
    push("pc_e", 6'b000000, 4'b1010, 0, 0, 9); cyc();
    idle(); PCSrcM = 1;
    push("pc_m", 6'b000000, 4'b1010, 0, 0, 9); cyc();
    idle(); PCSrcWB = 1;
    push("pc_wb", 6'b000000, 4'b0010, 0, 0, 9); cyc();
    idle();
    push("pc_idle", 6'b000000, 4'b0000, 0, 0, 9); cyc();
    idle(); BranchTakenE = 1;
    push("branch", 6'b000000, 4'b0011, 0, 0, 9); cyc();
    MemtoRegE = 1; wa3E = 5; raD = ra3(0, 5, 0);
    push("branch_hz", 6'b000000, 4'b1111, 0, 0, 9); cyc();

    // WAW stall, then reset with the counter at 2
    idle(); MulIssueE = 1; wa3E = 10;
    push("mul4_issue", 6'b000000, 4'b0000, 0, 0, 9); cyc();
    idle(); RegWriteD = 1; wa3D = 10;
    push("waw_stall", 6'b000000, 4'b1101, 1, 0, 10); cyc();
    rst_n = 1'b0;
    push("reset_mid_mul", 6'b000000, 4'b0011, 0, 0, 0); cyc();
    rst_n = 1'b1; raD = ra3(0, 0, 10);
    push("post_reset_no_stall", 6'b000000, 4'b0000, 0, 0, 0); cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      push("no_done_after_reset", 6'b000000, 4'b0000, 0, 0, 0); cyc();
    end

    // Multiply targeting the PC register is tracked but neither scoreboarded nor forwarded
    idle(); MulIssueE = 1; wa3E = PC;
    push("mul_pc_issue", 6'b000000, 4'b0000, 0, 0, 0); cyc();
    idle(); raD = ra3(0, 0, PC); RegWriteD = 1; wa3D = PC;
    push("pc_not_sb1", 6'b000000, 4'b0000, 1, 0, PC); cyc();
    push("pc_not_sb2", 6'b000000, 4'b0000, 1, 0, PC); cyc();
    raE = ra3(0, 0, PC);
    push("pc_no_mul_fwd", 6'b000000, 4'b0000, 1, 1, PC); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
